// File: rtl/ps2_mouse_hub.sv
// Multi-channel receive-only PS/2 mouse front end: one independent receiver per channel,
// decoding 3-byte stream packets into a clamped canvas cursor position plus button state.
module ps2_mouse_hub_ch #(
  parameter int CANVAS_WIDTH   = 360,
  parameter int CANVAS_HEIGHT  = 720,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int XW             = $clog2(CANVAS_WIDTH),
  parameter int YW             = $clog2(CANVAS_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          l_o,
  output logic          r_o,
  output logic          clkp_o,
  output logic          pv_o,
  output logic          err_o
);
  localparam int PXW = XW + 2;
  localparam int PYW = YW + 2;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PXW-1:0] XMAX   = PXW'(CANVAS_WIDTH - 1);
  localparam logic [PYW-1:0] YMAX   = PYW'(CANVAS_HEIGHT - 1);
  localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} fsm_e;

  fsm_e                   fsm_q;
  logic [SYNC_STAGES-1:0] cs_q, ds_q;
  logic                   prev_q;
  logic [2:0]             bit_q;
  logic [7:0]             sh_q, byte_q, st_q, b1_q;
  logic                   par_q, bvld_q;
  logic [1:0]             idx_q;
  logic [TW-1:0]          to_q;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   l_q, r_q, clkp_q, pv_q, err_q;

  logic           fall, dbit;
  logic [8:0]     dx, dy;
  logic [PXW-1:0] nx;
  logic [PYW-1:0] ny;

  assign dbit = ds_q[SYNC_STAGES-1];
  assign fall = prev_q & ~cs_q[SYNC_STAGES-1];

  // Widened unsigned math; the top bit going high means the result went negative.
  always_comb begin
    dx  = {st_q[4], b1_q};
    dy  = {st_q[5], byte_q};
    nx  = {2'b00, x_q} + {{(PXW-9){dx[8]}}, dx};
    ny  = {2'b00, y_q} - {{(PYW-9){dy[8]}}, dy};
    x_d = x_q;
    y_d = y_q;
    if (!st_q[6]) begin
      if (nx[PXW-1])     x_d = '0;
      else if (nx > XMAX) x_d = XMAX[XW-1:0];
      else               x_d = nx[XW-1:0];
    end
    if (!st_q[7]) begin
      if (ny[PYW-1])     y_d = '0;
      else if (ny > YMAX) y_d = YMAX[YW-1:0];
      else               y_d = ny[YW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q  <= S_IDLE;
      cs_q   <= '1;
      ds_q   <= '1;
      prev_q <= 1'b1;
      bit_q  <= '0;
      sh_q   <= '0;
      byte_q <= '0;
      st_q   <= '0;
      b1_q   <= '0;
      par_q  <= 1'b0;
      bvld_q <= 1'b0;
      idx_q  <= '0;
      to_q   <= '0;
      x_q    <= XW'(CANVAS_WIDTH / 2);
      y_q    <= YW'(CANVAS_HEIGHT / 2);
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      clkp_q <= 1'b0;
      pv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cs_q[0] <= ps2_clk_i;
      ds_q[0] <= ps2_data_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        cs_q[k] <= cs_q[k-1];
        ds_q[k] <= ds_q[k-1];
      end
      prev_q <= cs_q[SYNC_STAGES-1];
      pv_q   <= 1'b0;
      clkp_q <= 1'b0;
      err_q  <= 1'b0;
      bvld_q <= 1'b0;

      if (to_q == TO_MAX) begin
        fsm_q <= S_IDLE;
        idx_q <= '0;
        err_q <= 1'b1;
        to_q  <= '0;
      end else begin
        if (fall)                                   to_q <= '0;
        else if (fsm_q != S_IDLE || idx_q != 2'd0)  to_q <= to_q + 1'b1;

        // Packet assembly runs one cycle behind the frame FSM.
        if (bvld_q) begin
          case (idx_q)
            2'd0: if (byte_q[3]) begin st_q <= byte_q; idx_q <= 2'd1; end
            2'd1: begin b1_q <= byte_q; idx_q <= 2'd2; end
            default: begin
              idx_q  <= 2'd0;
              pv_q   <= 1'b1;
              x_q    <= x_d;
              y_q    <= y_d;
              l_q    <= st_q[0];
              r_q    <= st_q[1];
              clkp_q <= st_q[0] & ~l_q;
            end
          endcase
        end

        if (fall) begin
          case (fsm_q)
            S_IDLE: if (!dbit) begin fsm_q <= S_DATA; bit_q <= '0; end
            S_DATA: begin
              sh_q  <= {dbit, sh_q[7:1]};
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) fsm_q <= S_PAR;
            end
            S_PAR: begin par_q <= dbit; fsm_q <= S_STOP; end
            default: begin
              fsm_q <= S_IDLE;
              if (dbit && (^{sh_q, par_q})) begin
                byte_q <= sh_q;
                bvld_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
                idx_q <= '0;
              end
            end
          endcase
        end
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign l_o    = l_q;
  assign r_o    = r_q;
  assign clkp_o = clkp_q;
  assign pv_o   = pv_q;
  assign err_o  = err_q;
endmodule

module ps2_mouse_hub #(
  parameter int NUM_CH         = 2,
  parameter int CANVAS_WIDTH   = 360,
  parameter int CANVAS_HEIGHT  = 720,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int XW             = $clog2(CANVAS_WIDTH),
  parameter int YW             = $clog2(CANVAS_HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_CH-1:0]    ps2_clk_in,
  input  logic [NUM_CH-1:0]    ps2_data_in,
  output logic [NUM_CH*XW-1:0] mouse_x_out,
  output logic [NUM_CH*YW-1:0] mouse_y_out,
  output logic [NUM_CH-1:0]    click_out,
  output logic [NUM_CH-1:0]    right_out,
  output logic [NUM_CH-1:0]    click_pulse_out,
  output logic [NUM_CH-1:0]    pkt_valid_out,
  output logic [NUM_CH-1:0]    err_out
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ps2_mouse_hub_ch #(
      .CANVAS_WIDTH  (CANVAS_WIDTH),
      .CANVAS_HEIGHT (CANVAS_HEIGHT),
      .SYNC_STAGES   (SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .XW            (XW),
      .YW            (YW)
    ) u_ch (
      .clk_i     (clk_in),
      .rst_ni    (rst_in),
      .ps2_clk_i (ps2_clk_in[i]),
      .ps2_data_i(ps2_data_in[i]),
      .x_o       (mouse_x_out[i*XW +: XW]),
      .y_o       (mouse_y_out[i*YW +: YW]),
      .l_o       (click_out[i]),
      .r_o       (right_out[i]),
      .clkp_o    (click_pulse_out[i]),
      .pv_o      (pkt_valid_out[i]),
      .err_o     (err_out[i])
    );
  end
endmodule

// File: tb/tb_ps2_mouse_hub.sv
// Directed bench for ps2_mouse_hub: bit-bangs PS/2 frames per channel and checks
// cursor, buttons and pulse counts against hand-computed values.
module tb_ps2_mouse_hub;
  localparam int TO = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0 = 1'b1, c1 = 1'b1, d0 = 1'b1, d1 = 1'b1;
  logic [1:0]  ps2_clk, ps2_data;
  logic [17:0] mx;
  logic [19:0] my;
  logic [1:0]  click, right, cpulse, pvalid, err;

  int errs = 0, checks = 0;
  int pv[2], er[2], cp[2];
  int pv0, er0, cp0, pv1, er1, cp1;

  assign ps2_clk  = {c1, c0};
  assign ps2_data = {d1, d0};

  always #5 clk = ~clk;

  ps2_mouse_hub #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ps2_clk_in     (ps2_clk),
    .ps2_data_in    (ps2_data),
    .mouse_x_out    (mx),
    .mouse_y_out    (my),
    .click_out      (click),
    .right_out      (right),
    .click_pulse_out(cpulse),
    .pkt_valid_out  (pvalid),
    .err_out        (err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin pv[i] = 0; er[i] = 0; cp[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pvalid[i]) pv[i]++;
        if (err[i])    er[i]++;
        if (cpulse[i]) cp[i]++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_ln(input int ch, input logic c, input logic d);
    if (ch == 0) begin c0 = c; d0 = d; end
    else         begin c1 = c; d1 = d; end
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input int ch, input logic [7:0] b, input bit badpar,
                           input int nbits, input int hp);
    logic [10:0] fr;
    fr = {1'b1, (^b) ^ ~badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      set_ln(ch, 1'b1, fr[i]);
      cyc(hp);
      set_ln(ch, 1'b0, fr[i]);
      cyc(hp);
    end
    set_ln(ch, 1'b1, 1'b1);
    cyc(hp);
  endtask

  task automatic send_byte(input int ch, input logic [7:0] b, input bit badpar, input int hp);
    send_bits(ch, b, badpar, 11, hp);
    cyc(30);
  endtask

  task automatic send_pkt(input int ch, input logic [7:0] s, input logic [7:0] a,
                          input logic [7:0] c, input int hp);
    send_byte(ch, s, 1'b0, hp);
    send_byte(ch, a, 1'b0, hp);
    send_byte(ch, c, 1'b0, hp);
    cyc(20);
  endtask

  task automatic snap();
    pv0 = pv[0]; er0 = er[0]; cp0 = cp[0];
    pv1 = pv[1]; er1 = er[1]; cp1 = cp[1];
  endtask

  initial begin
    cyc(5);
    rst = 1'b1;
    cyc(50);
    // reset state, idle lines
    chk("rst_x0", int'(mx[8:0]), 180);
    chk("rst_y0", int'(my[9:0]), 360);
    chk("rst_x1", int'(mx[17:9]), 180);
    chk("rst_y1", int'(my[19:10]), 360);
    chk("rst_click", int'(click), 0);
    chk("rst_right", int'(right), 0);
    chk("rst_pv", pv[0] + pv[1], 0);
    chk("rst_err", er[0] + er[1], 0);

    // basic packet: L pressed, dx=+5, dy=+3 (up)
    snap();
    send_pkt(0, 8'h09, 8'h05, 8'h03, 20);
    chk("p1_pv0", pv[0] - pv0, 1);
    chk("p1_x0", int'(mx[8:0]), 185);
    chk("p1_y0", int'(my[9:0]), 357);
    chk("p1_click0", int'(click[0]), 1);
    chk("p1_cp0", cp[0] - cp0, 1);
    chk("p1_x1", int'(mx[17:9]), 180);
    chk("p1_pv1", pv[1] - pv1, 0);

    // dx=-200 clamps at 0, then dx=-1 stays at 0
    send_pkt(0, 8'h18, 8'h38, 8'h00, 20);
    chk("clamp_x0", int'(mx[8:0]), 0);
    chk("clamp_click0", int'(click[0]), 0);
    send_pkt(0, 8'h18, 8'hFF, 8'h00, 20);
    chk("clamp2_x0", int'(mx[8:0]), 0);
    chk("clamp2_y0", int'(my[9:0]), 357);

    // bad parity on byte1
    snap();
    send_byte(0, 8'h08, 1'b0, 20);
    send_byte(0, 8'h05, 1'b1, 20);
    cyc(20);
    chk("par_err0", er[0] - er0, 1);
    chk("par_pv0", pv[0] - pv0, 0);
    send_pkt(0, 8'h08, 8'h01, 8'h00, 20);
    chk("par_next_pv0", pv[0] - pv0, 1);
    chk("par_next_x0", int'(mx[8:0]), 1);

    // realign: status without bit3 is dropped silently
    snap();
    send_byte(0, 8'h00, 1'b0, 20);
    send_pkt(0, 8'h08, 8'h02, 8'h00, 20);
    chk("align_err0", er[0] - er0, 0);
    chk("align_pv0", pv[0] - pv0, 1);
    chk("align_x0", int'(mx[8:0]), 3);

    // X overflow holds x; right button and dy still apply
    send_pkt(0, 8'h4A, 8'h10, 8'h01, 20);
    chk("xovf_x0", int'(mx[8:0]), 3);
    chk("xovf_y0", int'(my[9:0]), 356);
    chk("xovf_right0", int'(right[0]), 1);

    // dy=-256 twice: 612 then clamps at 719
    send_pkt(0, 8'h28, 8'h00, 8'h00, 20);
    chk("ydn_y0", int'(my[9:0]), 612);
    send_pkt(0, 8'h28, 8'h00, 8'h00, 20);
    chk("yclamp_y0", int'(my[9:0]), 719);

    // timeout after a partial frame
    snap();
    send_bits(0, 8'h55, 1'b0, 5, 20);
    cyc(TO + 100);
    chk("to_err0", er[0] - er0, 1);
    chk("to_pv0", pv[0] - pv0, 0);
    send_pkt(0, 8'h08, 8'h01, 8'h00, 20);
    chk("to_next_x0", int'(mx[8:0]), 4);
    chk("to_next_pv0", pv[0] - pv0, 1);

    // both channels concurrently, different bit rates
    snap();
    fork
      send_pkt(0, 8'h09, 8'h02, 8'h01, 20);
      send_pkt(1, 8'h0B, 8'h14, 8'hFE, 27);
    join
    chk("cc_x0", int'(mx[8:0]), 6);
    chk("cc_y0", int'(my[9:0]), 718);
    chk("cc_click0", int'(click[0]), 1);
    chk("cc_right0", int'(right[0]), 0);
    chk("cc_cp0", cp[0] - cp0, 1);
    chk("cc_x1", int'(mx[17:9]), 200);
    chk("cc_y1", int'(my[19:10]), 106);
    chk("cc_click1", int'(click[1]), 1);
    chk("cc_right1", int'(right[1]), 1);
    chk("cc_cp1", cp[1] - cp1, 1);
    chk("cc_pv", (pv[0] - pv0) * 10 + (pv[1] - pv1), 11);
    chk("cc_err", (er[0] - er0) + (er[1] - er1), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
